// File: rtl/demux4_gather_pkg.sv
// Shared definitions for the 1-to-4 sample gatherer: lane width, slot and state encodings.
package demux4_gather_pkg;

    localparam int unsigned DATA_W = 15;
    localparam int unsigned N_LANE = 4;

    // Slot encodings match the select values used by the 4:1 tap mux on the read side.
    typedef enum logic [1:0] {
        SLOT_0 = 2'b00,
        SLOT_1 = 2'b01,
        SLOT_2 = 2'b10,
        SLOT_3 = 2'b11
    } slot_e;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/demux4_gather_dec2_4.sv
// 2-to-4 write-enable decoder: turns the write slot and the accept strobe into one-hot lane enables.
//   i_sel : lane index to write
//   i_en  : write strobe (accept)
//   o_en  : one-hot lane write enables (all zero when i_en is low)
module demux4_gather_dec2_4 (
    input  logic [1:0] i_sel,
    input  logic       i_en,
    output logic [3:0] o_en
);

    always_comb begin
        o_en        = '0;
        o_en[i_sel] = i_en;
    end

endmodule

// File: rtl/demux4_gather.sv
// Collects a serial stream of samples into four registered taps and hands the complete
// group to the bicubic kernel over a valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : incoming sample and its valid
//   in_first            : sample starts a new group (goes to out_0)
//   in_ready            : sample can be accepted this cycle (combinational from out_ready in FULL)
//   out_0..out_3        : registered taps of the current group
//   out_valid/out_ready : group handshake to the kernel
//   slot                : lane the next accepted sample will be written to
module demux4_gather #(
    parameter int unsigned DATA_W = demux4_gather_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_first,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_0,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        slot
);

    import demux4_gather_pkg::*;

    state_e            r_state;
    logic              r_out_valid;
    logic [1:0]        r_slot;
    logic [DATA_W-1:0] r_lane [N_LANE];

    logic       w_accept;
    logic       w_release;
    logic       w_restart;
    logic [1:0] w_wr_slot;
    logic [1:0] w_next_slot;
    logic [3:0] w_wr_en;

    // A full group only frees its lanes when the consumer takes it in the same cycle.
    assign in_ready  = ~rst & ((r_state == FILL) | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_release = r_out_valid & out_ready;

    // in_first, or any write while FULL (which implies a release), starts a new group at lane 0.
    assign w_restart   = in_first | (r_state == FULL);
    assign w_wr_slot   = w_restart ? SLOT_0 : r_slot;
    assign w_next_slot = 2'(w_wr_slot + 2'd1);

    demux4_gather_dec2_4 u_dec (
        .i_sel (w_wr_slot),
        .i_en  (w_accept),
        .o_en  (w_wr_en)
    );

    // Lane registers, slot counter and FILL/FULL state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_out_valid <= 1'b0;
            r_slot      <= SLOT_0;
            for (int i = 0; i < int'(N_LANE); i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_LANE); i++) begin
                if (w_wr_en[i]) begin
                    r_lane[i] <= in_data;
                end
            end

            if (w_accept) begin
                r_slot <= w_next_slot;
            end

            case (r_state)
                FILL: begin
                    if (w_accept && (w_wr_slot == SLOT_3)) begin
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    // Any accept here coincides with a release, so it always returns to FILL.
                    if (w_release) begin
                        r_state     <= FILL;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_0     = r_lane[0];
    assign out_1     = r_lane[1];
    assign out_2     = r_lane[2];
    assign out_3     = r_lane[3];
    assign out_valid = r_out_valid;
    assign slot      = r_slot;

endmodule

// File: tb/tb_demux4_gather.sv
// Self-checking bench for demux4_gather: hand-written vector table, directed corner
// sequences and a randomized run, all checked against a group-level reference model.
module tb_demux4_gather;

    localparam int unsigned DW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_0, out_1, out_2, out_3;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    slot;

    int n_vec = 0;
    int n_err = 0;

    demux4_gather dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot)
    );

    always #5 clk = ~clk;

    // Reference model: the group being assembled, where the next sample goes, and
    // whether a completed group is waiting for the consumer.
    logic [DW-1:0] m_lane [4];
    int            m_pos;
    bit            m_full;

    function automatic bit m_in_ready(bit r, bit ordy);
        return !r && (!m_full || ordy);
    endfunction

    task automatic m_step(bit r, bit v, logic [DW-1:0] d, bit f, bit ordy);
        bit acc;
        bit rel;
        int idx;
        if (r) begin
            for (int i = 0; i < 4; i++) m_lane[i] = '0;
            m_pos  = 0;
            m_full = 0;
            return;
        end
        acc = v && m_in_ready(r, ordy);
        rel = m_full && ordy;
        if (rel) m_full = 0;
        if (acc) begin
            // A new group starts on in_first or right after the previous group leaves.
            idx = (f || rel) ? 0 : m_pos;
            m_lane[idx] = d;
            m_pos = (idx + 1) % 4;
            if (idx == 3) m_full = 1;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_lanes();
        return 64'({out_3, out_2, out_1, out_0});
    endfunction

    function automatic logic [63:0] m_lanes();
        return 64'({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
    endfunction

    // One clock: drive at negedge, check in_ready, advance model, check registered outputs.
    task automatic tick(bit r, bit v, logic [DW-1:0] d, bit f, bit ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_first  = f;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_in_ready(r, ordy)));
        m_step(r, v, d, f, ordy);
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("slot", 64'(slot), 64'(m_pos));
        chk("lanes", dut_lanes(), m_lanes());
    endtask

    typedef struct packed {
        logic          r;
        logic          v;
        logic [DW-1:0] d;
        logic          f;
        logic          ordy;
        logic          e_rdy;
        logic          e_valid;
        logic [1:0]    e_slot;
        logic [59:0]   e_lanes;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, logic [DW-1:0] d, bit f, bit ordy,
                                bit e_rdy, bit e_valid, logic [1:0] e_slot,
                                logic [DW-1:0] l3, logic [DW-1:0] l2,
                                logic [DW-1:0] l1, logic [DW-1:0] l0);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.f = f; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_valid = e_valid; t.e_slot = e_slot;
        t.e_lanes = {l3, l2, l1, l0};
        return t;
    endfunction

    vec_t tbl [16];

    initial begin
        int vpos [$];
        bit r, v, f, o;
        logic [DW-1:0] d;
        logic [63:0] held;

        // rst, valid, data, first, out_ready | in_ready, out_valid, slot, lanes 3..0
        tbl[0]  = mk(1, 0, 15'h0000, 0, 0, 0, 0, 2'd0, 15'h000, 15'h000, 15'h000, 15'h000);
        tbl[1]  = mk(0, 1, 15'h0011, 0, 1, 1, 0, 2'd1, 15'h000, 15'h000, 15'h000, 15'h011);
        tbl[2]  = mk(0, 1, 15'h0022, 0, 1, 1, 0, 2'd2, 15'h000, 15'h000, 15'h022, 15'h011);
        tbl[3]  = mk(0, 1, 15'h0033, 0, 1, 1, 0, 2'd3, 15'h000, 15'h033, 15'h022, 15'h011);
        tbl[4]  = mk(0, 1, 15'h0044, 0, 1, 1, 1, 2'd0, 15'h044, 15'h033, 15'h022, 15'h011);
        tbl[5]  = mk(0, 0, 15'h0000, 0, 1, 1, 0, 2'd0, 15'h044, 15'h033, 15'h022, 15'h011);
        tbl[6]  = mk(0, 1, 15'h0100, 0, 1, 1, 0, 2'd1, 15'h044, 15'h033, 15'h022, 15'h100);
        tbl[7]  = mk(0, 1, 15'h0200, 0, 1, 1, 0, 2'd2, 15'h044, 15'h033, 15'h200, 15'h100);
        tbl[8]  = mk(0, 1, 15'h0300, 1, 1, 1, 0, 2'd1, 15'h044, 15'h033, 15'h200, 15'h300);
        tbl[9]  = mk(0, 1, 15'h0400, 0, 1, 1, 0, 2'd2, 15'h044, 15'h033, 15'h400, 15'h300);
        tbl[10] = mk(0, 1, 15'h0500, 0, 1, 1, 0, 2'd3, 15'h044, 15'h500, 15'h400, 15'h300);
        tbl[11] = mk(0, 1, 15'h0600, 0, 0, 1, 1, 2'd0, 15'h600, 15'h500, 15'h400, 15'h300);
        tbl[12] = mk(0, 1, 15'h7FFF, 0, 0, 0, 1, 2'd0, 15'h600, 15'h500, 15'h400, 15'h300);
        tbl[13] = mk(0, 1, 15'h7FFF, 0, 0, 0, 1, 2'd0, 15'h600, 15'h500, 15'h400, 15'h300);
        tbl[14] = mk(0, 1, 15'h7FFF, 0, 1, 1, 0, 2'd1, 15'h600, 15'h500, 15'h400, 15'h7FFF);
        tbl[15] = mk(1, 1, 15'h1234, 0, 1, 0, 0, 2'd0, 15'h000, 15'h000, 15'h000, 15'h000);

        for (int i = 0; i < 4; i++) m_lane[i] = '0;
        m_pos  = 0;
        m_full = 0;

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].ordy);
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].e_valid));
            chk("tbl_slot", 64'(slot), 64'(tbl[i].e_slot));
            chk("tbl_lanes", dut_lanes(), 64'(tbl[i].e_lanes));
        end

        // Back-to-back: 8 samples, out_valid pulses once per group, 4 cycles apart.
        tick(1, 0, '0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 15'(i + 1), 0, 1);
            if (out_valid) vpos.push_back(i);
        end
        chk("b2b_pulses", 64'(vpos.size()), 64'd2);
        if (vpos.size() == 2) begin
            chk("b2b_first", 64'(vpos[0]), 64'd3);
            chk("b2b_gap", 64'(vpos[1] - vpos[0]), 64'd4);
        end
        chk("b2b_group2", dut_lanes(), 64'({15'd8, 15'd7, 15'd6, 15'd5}));

        // Backpressure: lanes frozen for 5 cycles, then 0x7FFF lands on release.
        tick(0, 0, '0, 0, 1);
        tick(0, 1, 15'h00A, 0, 0);
        tick(0, 1, 15'h00B, 0, 0);
        tick(0, 1, 15'h00C, 0, 0);
        tick(0, 1, 15'h00D, 0, 0);
        held = dut_lanes();
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 15'h7FFF, 0, 0);
            chk("bp_hold", dut_lanes(), held);
        end
        tick(0, 1, 15'h7FFF, 0, 1);
        chk("bp_lane0", 64'(out_0), 64'h7FFF);

        // Reset mid-group, then again while FULL and stalled.
        tick(0, 1, 15'h111, 0, 1);
        tick(1, 1, 15'h222, 0, 1);
        tick(0, 1, 15'h001, 0, 0);
        tick(0, 1, 15'h002, 0, 0);
        tick(0, 1, 15'h003, 0, 0);
        tick(0, 1, 15'h004, 0, 0);
        tick(1, 1, 15'h005, 0, 0);
        chk("rst_full_lanes", dut_lanes(), 64'd0);

        // Width boundaries.
        tick(0, 1, 15'h7FFF, 0, 0);
        tick(0, 1, 15'h0000, 0, 0);
        tick(0, 1, 15'h4000, 0, 0);
        tick(0, 1, 15'h0001, 0, 0);
        chk("width_lanes", dut_lanes(), 64'({15'h0001, 15'h4000, 15'h0000, 15'h7FFF}));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(63) == 0);
            v = ($urandom_range(3) != 0);
            f = ($urandom_range(7) == 0);
            o = ($urandom_range(2) != 0);
            d = 15'($urandom);
            tick(r, v, d, f, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
